bcd_display_scanner: RTL and testbench

Time-multiplexed seven-segment driver that consumes the 4-bit BCD outputs of a chain of cascaded mod-10 decade counters and renders them on a common-bus, DIGITS-position display. It sits directly downstream of the decade-counter stages. Once per frame it snapshots all digit inputs, then steps one display position per SCAN_DIV enabled clocks. Per position it decodes BCD to segments, with leading-zero blanking and a dash for invalid codes.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/bcd_to_seg.sv | 32 +++
 rtl/bcd_display_scanner.sv | 94 +++++++++
 tb/tb_bcd_display_scanner.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Seven-segment constants shared by the display scanner and its decoder.
// Segment order is {g,f,e,d,c,b,a}, active high.
package seg_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder with a blank override.
// Codes above 9 render as a dash so bad counter outputs stay visible.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0] code,
  input  logic             blank,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (code)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed seven-segment scanner for a chain of decade counters.
// Digits are snapshotted once per frame so a frame never mixes two counts.
module bcd_display_scanner
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4,
  parameter bit LZB      = 1'b1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic [BCD_W*DIGITS-1:0]   digits,
  output logic [6:0]                seg,
  output logic [DIGITS-1:0]         an,
  output logic                      frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           next_idx;
  logic [BCD_W*DIGITS-1:0] snap;
  logic [BCD_W*DIGITS-1:0] src;
  logic                    step;
  logic                    wrap;
  logic [BCD_W-1:0]        code;
  logic                    blank;
  logic [DIGITS:0]         zero_from;
  logic [DIGITS-1:0]       an_d;
  logic [6:0]              seg_d;

  always_comb begin
    step     = en && (cnt == CNT_LAST);
    next_idx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    wrap     = (next_idx == '0);
    // On a wrap the incoming digits feed the decoder directly, so the new
    // frame shows on the same edge it is captured.
    src      = wrap ? digits : snap;

    zero_from         = '0;
    zero_from[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (src[BCD_W*i +: BCD_W] == '0);
    end

    code  = '0;
    an_d  = '0;
    blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (next_idx == IW'(i)) begin
        code    = src[BCD_W*i +: BCD_W];
        an_d[i] = 1'b1;
        blank   = LZB && (i != 0) && zero_from[i];
      end
    end
  end

  bcd_to_seg u_dec (
    .code  (code),
    .blank (blank),
    .seg   (seg_d)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      idx        <= IDX_LAST;
      snap       <= '0;
      seg        <= SEG_BLANK;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (step) begin
        cnt <= '0;
        idx <= next_idx;
        an  <= an_d;
        seg <= seg_d;
        if (wrap) begin
          snap       <= digits;
          frame_done <= 1'b1;
        end
      end else if (en) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: two instances (blanking on and off) share
// stimulus and are compared every cycle against an edge-count based model.
module tb_bcd_display_scanner;

  localparam int DG = 4;
  localparam int SD = 4;
  localparam int W  = 19;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [15:0] digits = 16'h0;

  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done_n;

  int checks = 0;
  int errors = 0;

  int          m_edges;
  logic [15:0] m_snap;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic [6:0]  m_segn;
  logic        m_fd;

  logic [W-1:0] exp_q[$];

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  logic [15:0] lz_pat [4] = '{16'h0090, 16'h0000, 16'h00A5, 16'hF000};

  bcd_display_scanner #(.DIGITS(DG), .SCAN_DIV(SD), .LZB(1'b1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .digits     (digits),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  bcd_display_scanner #(.DIGITS(DG), .SCAN_DIV(SD), .LZB(1'b0)) dut_nolzb (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .digits     (digits),
    .seg        (seg_n),
    .an         (an_n),
    .frame_done (frame_done_n)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int pos, input bit lzb);
    logic [15:0] upper;
    upper = v >> (4 * pos);
    if (lzb && pos > 0 && upper == 16'h0) return 7'h00;
    return seg_tab[upper[3:0]];
  endfunction

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 2) != 0) v[4*i +: 4] = 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_snap  = '0;
    m_an    = '0;
    m_seg   = '0;
    m_segn  = '0;
    m_fd    = 1'b0;
  endtask

  // Enabled edge k (counted from reset) lights position (k/SD - 1) mod DG
  // whenever k is a multiple of SD; position 0 takes a fresh snapshot.
  task automatic model_edge();
    int pos;
    m_fd = 1'b0;
    if (!rstn) begin
      model_reset();
    end else if (en) begin
      m_edges++;
      if (m_edges % SD == 0) begin
        pos = ((m_edges / SD) - 1) % DG;
        if (pos == 0) begin
          m_snap = digits;
          m_fd   = 1'b1;
        end
        m_an   = 4'(1 << pos);
        m_seg  = ref_seg(m_snap, pos, 1'b1);
        m_segn = ref_seg(m_snap, pos, 1'b0);
      end
    end
  endtask

  task automatic push_expected();
    exp_q.push_back({m_an, m_seg, m_segn, m_fd});
  endtask

  task automatic check_now();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check("an",           32'(an),           32'(e[18:15]));
    check("seg",          32'(seg),          32'(e[14:8]));
    check("frame_done",   32'(frame_done),   32'(e[0]));
    check("an_nolzb",     32'(an_n),         32'(e[18:15]));
    check("seg_nolzb",    32'(seg_n),        32'(e[7:1]));
    check("frame_done_n", 32'(frame_done_n), 32'(e[0]));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    push_expected();
    #1;
    check_now();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    model_reset();
    rstn   = 1'b0;
    en     = 1'b1;
    digits = 16'h1234;
    run(3);

    // basic count-up pattern, first frame directed
    rstn = 1'b1;
    run(4);
    check("first_an",  32'(an),         32'h1);
    check("first_seg", 32'(seg),        32'h66);
    check("first_fd",  32'(frame_done), 32'h1);
    run(12 + 2 * DG * SD);

    // snapshot isolation: change input while position 1 is lit
    for (int i = 0; i < 64 && m_an != 4'b0010; i++) tick();
    check("snap_pos", 32'(an), 32'h2);
    digits = 16'h5678;
    run(2 * DG * SD);

    // leading-zero and invalid-code patterns
    foreach (lz_pat[k]) begin
      digits = lz_pat[k];
      run(2 * DG * SD);
    end

    // enable freeze mid-position
    digits = 16'h1234;
    for (int i = 0; i < 64 && !m_fd; i++) tick();
    check("align_fd", 32'(frame_done), 32'h1);
    run(1);
    en = 1'b0;
    run(7);
    en = 1'b1;
    run(2 * DG * SD);

    // asynchronous reset between edges
    run(6);
    #3;
    rstn = 1'b0;
    model_reset();
    push_expected();
    #1;
    check_now();
    run(2);
    rstn = 1'b1;
    run(3 * DG * SD);

    // randomized stimulus
    for (int i = 0; i < 600; i++) begin
      if (i % 11 == 0) digits = rand_digits();
      en = ($urandom_range(0, 7) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
